pcie_read_scheduler: RTL

- Sequences host-memory DMA reads for the TX read-request path.
- Accepts one transfer command (host address + length in 64-bit words) and splits it into PCIe memory-read requests. Each request is at most MAX_READ_WORDS long and never crosses a 4 KB boundary.
- Allocates a tag per request from a pool of NTAGS and gates issue on receive-buffer credits.
- Sits between the DMA control registers and the TX engine's read-request port. The RX completion path frees tags and the consumer FIFO returns credits.

---
 rtl/pcie_dma_pkg.sv | 11 +
 rtl/pcie_tag_pool.sv | 55 +++++
 rtl/pcie_read_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared types and constants for the PCIe DMA read-request path
//   state_t    : scheduler FSM states
//   PAGE_BYTES : host page size a single read request must not cross
//   WORD_BYTES : bytes per data word
//   TAG_W      : width of the tag fields on the request/completion ports
package pcie_dma_pkg;
    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} state_t;
    localparam int PAGE_BYTES = 4096;
    localparam int WORD_BYTES = 8;
    localparam int TAG_W = 8;
endpackage

// File: rtl/pcie_tag_pool.sv
// pcie_tag_pool: bitmap of outstanding read tags with lowest-free selection
//   clock, reset_n   : clock, async active-low reset
//   alloc, alloc_tag : mark alloc_tag busy on this edge
//   free, free_tag   : release free_tag on this edge
//   avail, low_tag   : a tag is free / lowest-numbered free tag
//   outstanding      : registered count of busy tags
//   bad_free         : free of an out-of-range or already-free tag (combinational)
module pcie_tag_pool
    import pcie_dma_pkg::*;
#(
    parameter int NTAGS = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             alloc,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             free,
    input  logic [TAG_W-1:0] free_tag,
    output logic             avail,
    output logic [TAG_W-1:0] low_tag,
    output logic [5:0]       outstanding,
    output logic             bad_free
);
    logic [NTAGS-1:0] map, set_v, clr_v, map_nx;
    logic [5:0] cnt_nx;

    // Descending scan so the last hit is the lowest free tag.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        low_tag = '0;
        cnt_nx = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            set_v[i] = alloc && alloc_tag == TAG_W'(i);
            clr_v[i] = free && free_tag == TAG_W'(i) && map[i];
            if (!map[i]) low_tag = TAG_W'(i);
        end
        map_nx = (map | set_v) & ~clr_v;
        for (int i = 0; i < NTAGS; i++) cnt_nx = cnt_nx + 6'(map_nx[i]);
    end

    assign avail = ~&map;
    assign bad_free = free && ~|clr_v;

    // Count is taken from the next bitmap so it never lags the bitmap itself.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            map <= '0;
            outstanding <= '0;
        end else begin
            map <= map_nx;
            outstanding <= cnt_nx;
        end
    end
endmodule

// File: rtl/pcie_read_scheduler.sv
// pcie_read_scheduler: splits a DMA read transfer into tagged, credit-gated PCIe read requests
//   clock, reset_n                    : clock, async active-low reset
//   cmd_valid/ready/address/words     : transfer command (length in 64-bit words)
//   rr_valid/ready/address/words/tag  : read request to the TX engine
//   cpl_done, cpl_tag                 : final completion frees a tag
//   buf_release                       : consumer returns one word of buffer credit
//   busy, done, outstanding, err      : status; err is sticky
module pcie_read_scheduler
    import pcie_dma_pkg::*;
#(
    parameter int NTAGS = 8,
    parameter int MAX_READ_WORDS = 64,
    parameter int BUF_WORDS = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_address,
    input  logic [19:0]      cmd_words,
    output logic             rr_valid,
    input  logic             rr_ready,
    output logic [63:0]      rr_address,
    output logic [9:0]       rr_words,
    output logic [TAG_W-1:0] rr_tag,
    input  logic             cpl_done,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic             buf_release,
    output logic             busy,
    output logic             done,
    output logic [5:0]       outstanding,
    output logic             err
);
    localparam int CW = $clog2(BUF_WORDS) + 1;

    state_t state, state_nx;
    logic [63:0] addr;
    logic [19:0] rem;
    logic [CW-1:0] credits;
    logic [CW:0] credit_sum;
    logic [9:0] page_left, cap, chunk;
    logic [TAG_W-1:0] free_tag;
    logic tag_avail, bad_free, accept, hs, can_issue, credit_over;

    pcie_tag_pool #(.NTAGS(NTAGS)) u_pool (
        .clock(clock),
        .reset_n(reset_n),
        .alloc(hs),
        .alloc_tag(rr_tag),
        .free(cpl_done),
        .free_tag(cpl_tag),
        .avail(tag_avail),
        .low_tag(free_tag),
        .outstanding(outstanding),
        .bad_free(bad_free)
    );

    assign accept = cmd_valid && cmd_ready;
    assign hs = rr_valid && rr_ready;
    assign busy = state != IDLE;
    // Words left before the next 4 KB boundary; always 1..512 since addr is word aligned.
    assign page_left = 10'((PAGE_BYTES - int'(addr[11:0])) / WORD_BYTES);
    assign cap = (10'(MAX_READ_WORDS) < page_left) ? 10'(MAX_READ_WORDS) : page_left;
    assign chunk = (rem < 20'(cap)) ? rem[9:0] : cap;
    assign can_issue = tag_avail && 32'(credits) >= 32'(chunk);
    // Cannot underflow: a request only issues when credits cover it.
    assign credit_sum = {1'b0, credits} - (hs ? (CW+1)'(rr_words) : '0) + (CW+1)'(buf_release);
    assign credit_over = credit_sum > (CW+1)'(BUF_WORDS);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = (accept && cmd_words != '0) ? CALC : IDLE;
            CALC:  state_nx = can_issue ? ISSUE : CALC;
            ISSUE: state_nx = hs ? ((rem == 20'(rr_words)) ? DRAIN : CALC) : ISSUE;
            DRAIN: state_nx = (outstanding == '0) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cmd_ready <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            addr <= '0;
            rem <= '0;
            credits <= CW'(BUF_WORDS);
            rr_valid <= 1'b0;
            rr_address <= '0;
            rr_words <= '0;
            rr_tag <= '0;
        end else begin
            state <= state_nx;
            cmd_ready <= state_nx == IDLE;
            done <= (accept && cmd_words == '0) || (state == DRAIN && outstanding == '0);
            err <= err || bad_free || credit_over;
            credits <= credit_over ? CW'(BUF_WORDS) : credit_sum[CW-1:0];
            if (accept) begin
                addr <= cmd_address & ~64'h7;
                rem <= cmd_words;
            end
            if (state == CALC && can_issue) begin
                rr_valid <= 1'b1;
                rr_address <= addr;
                rr_words <= chunk;
                rr_tag <= free_tag;
            end
            if (hs) begin
                rr_valid <= 1'b0;
                addr <= addr + 64'(rr_words) * 64'(WORD_BYTES);
                rem <= rem - 20'(rr_words);
            end
        end
    end
endmodule
